// File: rtl/alu_result_stage.sv
// Result stage behind the reversible-logic ALU: per-op result select, status flags,
// and a small valid/ready FIFO with a running count of completed operations.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] xor_result,
    input  logic [WIDTH-1:0] not_result1,
    input  logic [WIDTH-1:0] and_result,
    input  logic [WIDTH-1:0] nand_result,
    input  logic [WIDTH-1:0] or_result,
    input  logic [WIDTH-1:0] nor_result,
    input  logic [WIDTH-1:0] a_b_one_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_parity,
    output logic [CNT_W-1:0] op_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_result [DEPTH];
    logic [TAG_W-1:0] mem_tag    [DEPTH];
    logic [2:0]       mem_flags  [DEPTH];

    // Last popped entry, shown while the FIFO is empty.
    logic [WIDTH-1:0] last_result;
    logic [TAG_W-1:0] last_tag;
    logic [2:0]       last_flags;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic [WIDTH-1:0] sel_result;
    logic [2:0]       sel_flags;
    logic             push;
    logic             pop;

    always_comb begin
        sel_result = in_a;
        case (in_op)
            3'd0:    sel_result = xor_result;
            3'd1:    sel_result = not_result1;
            3'd2:    sel_result = and_result;
            3'd3:    sel_result = nand_result;
            3'd4:    sel_result = or_result;
            3'd5:    sel_result = nor_result;
            3'd6:    sel_result = a_b_one_result;
            default: sel_result = in_a;
        endcase
    end

    // Flag bit order: {zero, neg, parity}.
    assign sel_flags = {(sel_result == '0), sel_result[WIDTH-1], ^sel_result};

    assign in_ready  = (occ < OCC_W'(DEPTH));
    assign out_valid = (occ != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_result[i] <= '0;
                mem_tag[i]    <= '0;
                mem_flags[i]  <= '0;
            end
            last_result <= '0;
            last_tag    <= '0;
            last_flags  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            op_count    <= '0;
        end else begin
            if (push) begin
                mem_result[wr_ptr] <= sel_result;
                mem_tag[wr_ptr]    <= in_tag;
                mem_flags[wr_ptr]  <= sel_flags;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                last_result <= mem_result[rd_ptr];
                last_tag    <= mem_tag[rd_ptr];
                last_flags  <= mem_flags[rd_ptr];
                rd_ptr      <= rd_ptr + PTR_W'(1);
                op_count    <= op_count + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign out_result = out_valid ? mem_result[rd_ptr] : last_result;
    assign out_tag    = out_valid ? mem_tag[rd_ptr]    : last_tag;
    assign {out_zero, out_neg, out_parity} = out_valid ? mem_flags[rd_ptr] : last_flags;

endmodule
